io_port_bank: RTL
=================

// Module: io_port_bank
// PURPOSE
//  Parametrised Z80 I/O port register bank, generalising the fixed #FE/#7FFD/#DFFD/#1FFD decode.
//  Per port: address/mask match, enable gating, write-once lock, sticky-lock override and readback.
//  An I/O-cycle FSM commits exactly one write per IOREQ cycle, however long WR is held at clk28.
//  Registered, priority-muxed read data feeds the top-level data-bus controller (d_out/d_out_active).
// PARAMETERS
//  NUM_PORTS   8        number of port registers (1..16)
//  DATA_W      8        register width (1..8); zero-extended onto the 8-bit bus on read
//  ADDR_MATCH  '{..}    [NUM_PORTS][16] address value per port
//  ADDR_MASK   '{..}    [NUM_PORTS][16] 1 = bit compared; 16'h0002 decodes like #7FFD's A1=0 style
//  RESET_VAL   '{0..}   [NUM_PORTS][DATA_W] register value after reset
//  LOCK_BIT    '{-1..}  [NUM_PORTS] data bit that sets the lock on write; -1 = port never locks
//  READBACK    '0       [NUM_PORTS] 1 = reads return register; 0 = reads return ext_rd_data[i]
// PORTS
//  clk28          in   1              system clock
//  rst            in   1              synchronous, active-high reset
//  bus            intf cpu_bus        a[15:0], d[7:0], rd, wr, ioreq (already synchronised to clk28)
//  port_en        in   NUM_PORTS      per-port decode enable (machine/magic_map qualification)
//  lock_ovr       in   NUM_PORTS      1 = ignore lock for port i (e.g. #DFFD bit4 style)
//  ext_rd_data    in   NUM_PORTS*8    read source for non-readback ports
//  port_q         out  NUM_PORTS*DATA_W current register values
//  port_wstb      out  NUM_PORTS      1-cycle pulse in the cycle port_q[i] takes the new value
//  port_locked    out  NUM_PORTS      lock state
//  d_out          out  8              registered read data
//  d_out_active   out  1              registered read-valid
//  rd_conflict    out  1              1-cycle pulse: >1 enabled port matched a read
// BEHAVIOUR
//  Reset (sync): port_q = RESET_VAL, port_locked = 0, port_wstb = 0, d_out = 8'hFF,
//   d_out_active = 0, rd_conflict = 0, FSM = S_HOLD.
//  match[i] = port_en[i] && ((bus.a ^ ADDR_MATCH[i]) & ADDR_MASK[i]) == 0.
//  FSM (one per bank): S_IDLE, S_HOLD.
//   S_IDLE: ioreq && wr -> commit, go S_HOLD; ioreq && rd -> go S_HOLD; else stay.
//   S_HOLD: stay while ioreq; ioreq low -> S_IDLE. Write/read never re-commits in S_HOLD.
//   Reset into S_HOLD: an IOREQ cycle straddling reset release is never committed.
//  Commit (S_IDLE edge): for every i with match[i] && (!port_locked[i] || lock_ovr[i]):
//   port_q[i] <= bus.d[DATA_W-1:0] and port_wstb[i] = 1 at the next clk28 edge (latency 1).
//   All matching ports commit simultaneously (aliasing is legal, as #7FFD/#1FFD partial decode).
//   LOCK_BIT[i] >= 0 and bus.d[LOCK_BIT[i]] = 1 -> port_locked[i] <= 1 in the same edge.
//   Locked port written with lock_ovr[i] = 1: data and lock bit both update (lock can clear).
//   Lock never clears otherwise; only rst or an override write.
//  Read: d_out_active <= ioreq && rd && |match, registered every cycle while rd held (not one-shot).
//   d_out <= data of lowest matching index; readback -> {zero-ext port_q[i]}, else ext_rd_data[i].
//   No match -> d_out_active = 0, d_out holds last value.
//   rd_conflict pulses when popcount(match) > 1 in a read cycle (S_IDLE entry only).
//  ioreq with both rd and wr: write wins; no read output.
//  port_en dropping mid-cycle: no effect on an already-committed write; read data drops next edge.
// STRUCTURE
//  common package: IO_PORTS_MAX = 16, typedef enum logic {S_IDLE, S_HOLD} io_state_t,
//   typedef logic [15:0] io_addr_t.
//  Sub-module io_port_match: combinational per-port address/mask/enable compare -> match vector,
//   plus lowest-index encoder and multi-hit flag; instantiated once.
//  Top: FSM, register array (generate loop), lock array, read mux/register.
// TESTING
//  1 rst held with ioreq=wr=1, a=16'h7FFD, d=8'h17; release rst -> no port_wstb, port_q = RESET_VAL
//    until ioreq falls; next clean write of 8'h17 -> port_q = 8'h17, single wstb pulse.
//  2 Write 16'h7FFD d=8'h03 with wr held 20 clk28 cycles -> exactly one port_wstb pulse,
//    port_q = 8'h03 one cycle after commit.
//  3 LOCK_BIT=5: write 8'h20 -> port_locked = 1; write 8'h07 -> port_q stays 8'h20;
//    lock_ovr=1, write 8'h07 -> port_q = 8'h07, port_locked = 0.
//  4 Ports 1 (A1=0 mask 16'h8002) and 2 (16'h1FFD mask 16'hF002) both match a=16'h1FFD write
//    d=8'h04 -> both update in the same cycle; read at that address -> d_out = port 1,
//    d_out_active = 1, rd_conflict pulses once.
//  5 READBACK[0]=0, ext_rd_data[0]=8'hBF, read a=16'h00FE -> d_out=8'hBF, d_out_active=1
//    one cycle after rd; port_en[0]=0 -> d_out_active = 0.
//  6 rd and wr high together at a matching address -> register updates, d_out_active stays 0.

Source files
------------

// File: rtl/io_port_bank_pkg.sv
// Shared types and limits for the Z80 I/O port register bank.
//   IO_PORTS_MAX : upper bound on the number of ports in one bank.
//   io_state_t   : I/O-cycle FSM state (S_IDLE waits for a cycle, S_HOLD waits for IOREQ to end).
//   io_addr_t    : 16-bit Z80 I/O address.
package io_port_bank_pkg;

  localparam int IO_PORTS_MAX = 16;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } io_state_t;

  typedef logic [15:0] io_addr_t;

endpackage

// File: rtl/io_port_bank_match.sv
// Combinational address decoder for the I/O port bank.
// Ports:
//   a_i         in  16         CPU I/O address
//   port_en_i   in  NUM_PORTS  per-port decode enable
//   match_o     out NUM_PORTS  port i is enabled and its masked address compares equal
//   hit_o       out 1          at least one port matched
//   first_idx_o out 4          lowest matching port index (0 when nothing matched)
//   multi_hit_o out 1          more than one port matched (aliased decode)
module io_port_match
  import io_port_bank_pkg::*;
#(
  parameter int       NUM_PORTS              = 8,
  parameter io_addr_t ADDR_MATCH [NUM_PORTS] = '{default: 16'h0000},
  parameter io_addr_t ADDR_MASK  [NUM_PORTS] = '{default: 16'hFFFF}
) (
  input  logic [15:0]          a_i,
  input  logic [NUM_PORTS-1:0] port_en_i,
  output logic [NUM_PORTS-1:0] match_o,
  output logic                 hit_o,
  output logic [3:0]           first_idx_o,
  output logic                 multi_hit_o
);

  // A mask bit of 1 means the address bit takes part in the compare.
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_cmp
    assign match_o[i] = port_en_i[i] && (((a_i ^ ADDR_MATCH[i]) & ADDR_MASK[i]) == 16'h0000);
  end

  assign hit_o       = |match_o;
  assign multi_hit_o = ($countones(match_o) > 1);

  // Lowest index wins so the read mux has a fixed priority.
  always_comb begin
    logic found;
    found       = 1'b0;
    first_idx_o = 4'd0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (match_o[i] && !found) begin
        first_idx_o = 4'(i);
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_port_bank.sv
// Parametrised Z80 I/O port register bank.
// Each port has an address/mask decode, an enable, an optional write-once lock bit with a
// per-port override, and either register readback or an external read source. An I/O-cycle
// FSM commits exactly one write per IOREQ cycle however long WR is held.
// Ports:
//   clk28        in  1                 system clock
//   rst          in  1                 synchronous active-high reset
//   bus_a        in  16                CPU address (synchronised to clk28)
//   bus_d        in  8                 CPU write data
//   bus_rd       in  1                 read strobe
//   bus_wr       in  1                 write strobe
//   bus_ioreq    in  1                 I/O request
//   port_en      in  NUM_PORTS         per-port decode enable
//   lock_ovr     in  NUM_PORTS         ignore the lock of port i (and allow the write to clear it)
//   ext_rd_data  in  NUM_PORTS*8       read source for ports without readback
//   port_q       out NUM_PORTS*DATA_W  current register values, port i at [i*DATA_W +: DATA_W]
//   port_wstb    out NUM_PORTS         1-cycle pulse in the cycle port_q[i] takes a new value
//   port_locked  out NUM_PORTS         lock state
//   d_out        out 8                 registered read data (holds when nothing is read)
//   d_out_active out 1                 registered read-valid
//   rd_conflict  out 1                 1-cycle pulse: a read hit more than one enabled port
//   dbg_state    out 1                 FSM state (0 = S_IDLE, 1 = S_HOLD)
module io_port_bank
  import io_port_bank_pkg::*;
#(
  parameter int          NUM_PORTS              = 8,
  parameter int          DATA_W                 = 8,
  parameter io_addr_t    ADDR_MATCH [NUM_PORTS] = '{16'h00FE, 16'h7FFD, 16'h1FFD, 16'hDFFD,
                                                    16'hFF10, 16'hFF20, 16'hFF30, 16'hFF40},
  parameter io_addr_t    ADDR_MASK  [NUM_PORTS] = '{16'h0001, 16'h8002, 16'hF002, 16'hF002,
                                                    16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF},
  parameter logic [DATA_W-1:0] RESET_VAL [NUM_PORTS] = '{default: '0},
  parameter int          LOCK_BIT   [NUM_PORTS] = '{default: -1},
  parameter logic [NUM_PORTS-1:0] READBACK      = '0
) (
  input  logic                        clk28,
  input  logic                        rst,
  input  logic [15:0]                 bus_a,
  input  logic [7:0]                  bus_d,
  input  logic                        bus_rd,
  input  logic                        bus_wr,
  input  logic                        bus_ioreq,
  input  logic [NUM_PORTS-1:0]        port_en,
  input  logic [NUM_PORTS-1:0]        lock_ovr,
  input  logic [NUM_PORTS*8-1:0]      ext_rd_data,
  output logic [NUM_PORTS*DATA_W-1:0] port_q,
  output logic [NUM_PORTS-1:0]        port_wstb,
  output logic [NUM_PORTS-1:0]        port_locked,
  output logic [7:0]                  d_out,
  output logic                        d_out_active,
  output logic                        rd_conflict,
  output logic                        dbg_state
);

  io_state_t            state_q;
  logic [DATA_W-1:0]    port_reg_q [NUM_PORTS];
  logic [NUM_PORTS-1:0] locked_q;
  logic [NUM_PORTS-1:0] wstb_q;
  logic [7:0]           d_out_q;
  logic                 d_out_active_q;
  logic                 rd_conflict_q;

  logic [NUM_PORTS-1:0] match;
  logic                 hit;
  logic                 multi_hit;
  logic [3:0]           first_idx;

  io_port_match #(
    .NUM_PORTS  (NUM_PORTS),
    .ADDR_MATCH (ADDR_MATCH),
    .ADDR_MASK  (ADDR_MASK)
  ) u_match (
    .a_i         (bus_a),
    .port_en_i   (port_en),
    .match_o     (match),
    .hit_o       (hit),
    .first_idx_o (first_idx),
    .multi_hit_o (multi_hit)
  );

  // Write wins when RD and WR are both asserted, so a read cycle requires WR low.
  logic wr_cycle;
  logic rd_cycle;
  logic commit_edge;
  assign wr_cycle    = bus_ioreq && bus_wr;
  assign rd_cycle    = bus_ioreq && bus_rd && !bus_wr;
  assign commit_edge = (state_q == S_IDLE) && wr_cycle;

  logic [NUM_PORTS-1:0] commit;
  logic [NUM_PORTS-1:0] lock_d;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign commit[i] = commit_edge && match[i] && (!locked_q[i] || lock_ovr[i]);

    // The new lock state is simply the lock bit of the written data: an unlocked port written
    // with the bit clear stays unlocked, and an override write can clear an existing lock.
    if (LOCK_BIT[i] >= 0) begin : g_lock
      localparam logic [2:0] LB = 3'(LOCK_BIT[i]);
      assign lock_d[i] = bus_d[LB];
    end else begin : g_nolock
      assign lock_d[i] = 1'b0;
    end

    assign port_q[i*DATA_W +: DATA_W] = port_reg_q[i];
  end

  // Per-port read data, zero-extended onto the 8-bit bus. Sized to the maximum bank so the
  // 4-bit priority index always addresses a valid entry.
  logic [7:0] rd_src [IO_PORTS_MAX];
  always_comb begin
    for (int k = 0; k < IO_PORTS_MAX; k++) begin
      rd_src[k] = 8'h00;
    end
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (READBACK[k]) begin
        rd_src[k][DATA_W-1:0] = port_reg_q[k];
      end else begin
        rd_src[k] = ext_rd_data[k*8 +: 8];
      end
    end
  end

  // Reset lands in S_HOLD so an IOREQ cycle already in progress at reset release is ignored.
  always_ff @(posedge clk28) begin
    if (rst) begin
      state_q <= S_HOLD;
      for (int k = 0; k < NUM_PORTS; k++) begin
        port_reg_q[k] <= RESET_VAL[k];
      end
      locked_q       <= '0;
      wstb_q         <= '0;
      d_out_q        <= 8'hFF;
      d_out_active_q <= 1'b0;
      rd_conflict_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (bus_ioreq && (bus_wr || bus_rd)) state_q <= S_HOLD;
        S_HOLD: if (!bus_ioreq) state_q <= S_IDLE;
      endcase

      for (int k = 0; k < NUM_PORTS; k++) begin
        if (commit[k]) begin
          port_reg_q[k] <= bus_d[DATA_W-1:0];
        end
      end
      locked_q <= (locked_q & ~commit) | (lock_d & commit);
      wstb_q   <= commit;

      // Read output is refreshed every cycle RD is held; only the conflict flag is one-shot.
      d_out_active_q <= rd_cycle && hit;
      if (rd_cycle && hit) begin
        d_out_q <= rd_src[first_idx];
      end
      rd_conflict_q <= (state_q == S_IDLE) && rd_cycle && multi_hit;
    end
  end

  assign port_wstb    = wstb_q;
  assign port_locked  = locked_q;
  assign d_out        = d_out_q;
  assign d_out_active = d_out_active_q;
  assign rd_conflict  = rd_conflict_q;
  assign dbg_state    = state_q;

endmodule
